// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, protocol constants and header offsets for the UDP receive path
package eth_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_CHECK, S_DROP
   } state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL    = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
   localparam logic [10:0] HDR_LEN       = 11'd42;
   localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
   localparam logic [2:0]  FCS_LEN       = 3'd4;
   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   // byte offsets from the first destination MAC byte
   localparam logic [10:0] OFF_MAC_LAST  = 11'd5;
   localparam logic [10:0] OFF_ETH_TYPE  = 11'd12;
   localparam logic [10:0] OFF_VER_IHL   = 11'd14;
   localparam logic [10:0] OFF_IP_PROTO  = 11'd23;
   localparam logic [10:0] OFF_SRC_PORT  = 11'd34;
   localparam logic [10:0] OFF_DST_PORT  = 11'd36;
   localparam logic [10:0] OFF_UDP_LEN   = 11'd38;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rx_calc_crc32.sv
// rx_calc_crc32: byte-wide CRC32 accumulator, register kept in non-reflected bit order
module rx_calc_crc32
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q, crc_d;

   // fold one byte in, least significant bit first
   always_comb begin
      crc_d = crc_q;
      for (int i = 0; i < 8; i++)
         crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ data_i[i]) ? CRC32_POLY : 32'd0);
   end

   // preset at start of frame, accumulate on enabled bytes
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)
         crc_q <= '1;
      else if (init_i)
         crc_q <= '1;
      else if (en_i)
         crc_q <= crc_d;

   assign crc_o = crc_q;

endmodule

// File: rtl/recv_udp_block.sv
// recv_udp_block: GMII receive, Ethernet/IPv4/UDP header filter, payload to RAM, FCS check
module recv_udp_block
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
   parameter logic [15:0] LOCAL_PORT = 16'd5000,
   parameter logic [10:0] MAX_LEN    = 11'd1472
) (
   input  logic        i_rx_clk,
   input  logic        rst_n,
   input  logic        i_rx_dv,
   input  logic        i_rx_er,
   input  logic [7:0]  i_rx_data,
   output logic        o_wr_en,
   output logic [10:0] o_wr_addr,
   output logic [7:0]  o_wr_data,
   output logic        o_valid,
   output logic [10:0] o_data_len,
   output logic [15:0] o_src_port,
   input  logic        i_release,
   output logic [15:0] o_drop_cnt
);

   state_t      state_q;
   logic [10:0] cnt_q, len_q, data_len_q, wr_addr_q;
   logic [7:0]  len_hi_q, wr_data_q;
   logic [15:0] src_cap_q, src_port_q, drop_q;
   logic [2:0]  tail_q;
   logic        mac_loc_q, mac_bc_q, wr_en_q, valid_q;
   logic [7:0]  mac_b;
   logic [15:0] udp_len;
   logic [31:0] crc;
   logic        mac_loc_n, mac_bc_n, hdr_bad, crc_init, crc_en;

   // expected destination MAC byte for the current header index (byte 0 is the MSB)
   assign mac_b     = 8'(LOCAL_MAC >> (6'd40 - {cnt_q[2:0], 3'b000}));
   assign mac_loc_n = mac_loc_q && i_rx_data == mac_b;
   assign mac_bc_n  = mac_bc_q && i_rx_data == 8'hFF;
   assign udp_len   = {len_hi_q, i_rx_data};

   assign hdr_bad = (cnt_q == OFF_MAC_LAST && !(mac_loc_n || mac_bc_n))
      || (cnt_q == OFF_ETH_TYPE && i_rx_data != ETH_TYPE_IPV4[15:8])
      || (cnt_q == OFF_ETH_TYPE + 11'd1 && i_rx_data != ETH_TYPE_IPV4[7:0])
      || (cnt_q == OFF_VER_IHL && i_rx_data != IP_VER_IHL)
      || (cnt_q == OFF_IP_PROTO && i_rx_data != IP_PROTO_UDP)
      || (cnt_q == OFF_DST_PORT && i_rx_data != LOCAL_PORT[15:8])
      || (cnt_q == OFF_DST_PORT + 11'd1 && i_rx_data != LOCAL_PORT[7:0])
      || (cnt_q == OFF_UDP_LEN + 11'd1
          && (udp_len <= UDP_HDR_LEN || udp_len > {5'd0, MAX_LEN} + UDP_HDR_LEN));

   assign crc_init = state_q == S_PREAMBLE && i_rx_dv && !i_rx_er && i_rx_data == SFD_BYTE;
   assign crc_en   = i_rx_dv && !i_rx_er
                     && (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_TAIL);

   rx_calc_crc32 u_crc (
      .clk_i  (i_rx_clk),
      .rst_ni (rst_n),
      .init_i (crc_init),
      .en_i   (crc_en),
      .data_i (i_rx_data),
      .crc_o  (crc)
   );

   // frame receive state machine with registered RAM, status and drop outputs
   always_ff @(posedge i_rx_clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         len_hi_q   <= '0;
         src_cap_q  <= '0;
         tail_q     <= '0;
         mac_loc_q  <= 1'b0;
         mac_bc_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         valid_q    <= 1'b0;
         data_len_q <= '0;
         src_port_q <= '0;
         drop_q     <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (i_release)
            valid_q <= 1'b0;
         case (state_q)
            S_IDLE:
               if (i_rx_dv)
                  state_q <= (i_rx_data == PREAMBLE_BYTE && !i_rx_er) ? S_PREAMBLE : S_DROP;
            S_PREAMBLE:
               if (!i_rx_dv)
                  state_q <= S_IDLE;
               else if (i_rx_er)
                  state_q <= S_DROP;
               else if (i_rx_data == SFD_BYTE) begin
                  state_q   <= valid_q ? S_DROP : S_HEADER;
                  cnt_q     <= '0;
                  mac_loc_q <= 1'b1;
                  mac_bc_q  <= 1'b1;
               end else if (i_rx_data != PREAMBLE_BYTE)
                  state_q <= S_DROP;
            S_HEADER:
               if (!i_rx_dv) begin
                  drop_q  <= sat_inc(drop_q);
                  state_q <= S_IDLE;
               end else if (i_rx_er || hdr_bad)
                  state_q <= S_DROP;
               else begin
                  cnt_q     <= (cnt_q == HDR_LEN - 11'd1) ? 11'd0 : cnt_q + 11'd1;
                  mac_loc_q <= mac_loc_n;
                  mac_bc_q  <= mac_bc_n;
                  if (cnt_q == OFF_SRC_PORT)
                     src_cap_q[15:8] <= i_rx_data;
                  if (cnt_q == OFF_SRC_PORT + 11'd1)
                     src_cap_q[7:0] <= i_rx_data;
                  if (cnt_q == OFF_UDP_LEN)
                     len_hi_q <= i_rx_data;
                  if (cnt_q == OFF_UDP_LEN + 11'd1)
                     len_q <= udp_len[10:0] - UDP_HDR_LEN[10:0];
                  if (cnt_q == HDR_LEN - 11'd1)
                     state_q <= S_PAYLOAD;
               end
            S_PAYLOAD:
               if (!i_rx_dv) begin
                  drop_q  <= sat_inc(drop_q);
                  state_q <= S_IDLE;
               end else if (i_rx_er)
                  state_q <= S_DROP;
               else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cnt_q;
                  wr_data_q <= i_rx_data;
                  cnt_q     <= cnt_q + 11'd1;
                  if (cnt_q == len_q - 11'd1) begin
                     state_q <= S_TAIL;
                     tail_q  <= '0;
                  end
               end
            S_TAIL:
               if (!i_rx_dv)
                  state_q <= S_CHECK;
               else if (i_rx_er)
                  state_q <= S_DROP;
               else if (tail_q != FCS_LEN)
                  tail_q <= tail_q + 3'd1;
            S_CHECK: begin
               if (crc == CRC32_RESIDUE && tail_q == FCS_LEN) begin
                  valid_q    <= 1'b1;
                  data_len_q <= len_q;
                  src_port_q <= src_cap_q;
               end else
                  drop_q <= sat_inc(drop_q);
               state_q <= S_IDLE;
            end
            S_DROP:
               if (!i_rx_dv) begin
                  drop_q  <= sat_inc(drop_q);
                  state_q <= S_IDLE;
               end
            default:
               state_q <= S_IDLE;
         endcase
      end

   assign o_wr_en    = wr_en_q;
   assign o_wr_addr  = wr_addr_q;
   assign o_wr_data  = wr_data_q;
   assign o_valid    = valid_q;
   assign o_data_len = data_len_q;
   assign o_src_port = src_port_q;
   assign o_drop_cnt = drop_q;

endmodule
